// File: rtl/gps_pkg.sv
// Shared types and constants for the GPS local-clock block: FSM states,
// ASCII digit bounds and the legal ranges of a UTC time field.
package gps_pkg;

    typedef enum logic [1:0] {
        ST_UNSYNC   = 2'd0,
        ST_CHECK    = 2'd1,
        ST_RUN      = 2'd2,
        ST_HOLDOVER = 2'd3
    } gps_state_e;

    localparam logic [7:0] ASCII_0 = 8'h30;
    localparam logic [7:0] ASCII_9 = 8'h39;

    localparam logic [6:0] HR_MAX  = 7'd23;
    localparam logic [6:0] MIN_MAX = 7'd59;
    localparam logic [6:0] SEC_MAX = 7'd59;

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= ASCII_0) && (c <= ASCII_9);
    endfunction

endpackage

// File: rtl/gps_local_clock_if.sv
// Parser-facing time input and schedule-facing local time outputs of gps_local_clock.
interface gps_local_clock_if;

    logic [47:0] time_in;
    logic        time_in_valid;
    logic [4:0]  hour_out;
    logic [5:0]  min_out;
    logic [5:0]  sec_out;
    logic        sec_tick;
    logic        time_valid;
    logic        sync_err;

    modport master (
        output time_in, time_in_valid,
        input  hour_out, min_out, sec_out, sec_tick, time_valid, sync_err
    );

    modport slave (
        input  time_in, time_in_valid,
        output hour_out, min_out, sec_out, sec_tick, time_valid, sync_err
    );

endinterface

// File: rtl/ascii_pair_dec.sv
// Converts two ASCII characters (tens, units) into a binary value 0..99.
// bin is meaningless unless digit_ok is set.
module ascii_pair_dec
    import gps_pkg::*;
(
    input  logic [7:0] tens,
    input  logic [7:0] units,
    output logic [6:0] bin,
    output logic       digit_ok
);

    assign digit_ok = is_digit(tens) && is_digit(units);
    assign bin      = 7'(tens[3:0]) * 7'd10 + 7'(units[3:0]);

endmodule

// File: rtl/gps_local_clock.sv
// Validates NMEA hhmmss frames, converts them to local time with a fixed
// time-zone offset and free-runs a 1 Hz clock between fixes.
module gps_local_clock
    import gps_pkg::*;
#(
    parameter int CLKS_PER_SEC = 50_000_000,
    parameter int TZ_OFFSET_HR = -5,
    parameter int STALE_SEC    = 10
) (
    input  logic              CLK,
    input  logic              RST_N,
    gps_local_clock_if.slave  bus
);

    localparam int PW = $clog2(CLKS_PER_SEC);
    localparam int SW = $clog2(STALE_SEC + 1);
    localparam logic [PW-1:0]      PRESC_LAST = PW'(CLKS_PER_SEC - 1);
    localparam logic [SW-1:0]      STALE_LAST = SW'(STALE_SEC - 1);
    localparam logic [SW-1:0]      STALE_MAX  = SW'(STALE_SEC);
    localparam logic signed [7:0]  TZ8        = 8'(TZ_OFFSET_HR);

    gps_state_e state_q, state_d;
    gps_state_e ret_q, ret_d;
    logic       capture;

    logic [47:0]   frame_q;
    logic [PW-1:0] presc_q;
    logic [SW-1:0] stale_q;
    logic [4:0]    hour_q;
    logic [5:0]    min_q;
    logic [5:0]    sec_q;
    logic          tick_q;
    logic          valid_q;
    logic          err_q;

    logic [6:0] hr_bin, mn_bin, sc_bin;
    logic       hr_dig, mn_dig, sc_dig;
    logic       frame_ok;
    logic signed [7:0] hr_sum;
    logic [4:0] hr_local;

    logic load, reject, running, wrap, tick_now, stale_hit;

    ascii_pair_dec u_dec_hr (
        .tens     (frame_q[47:40]),
        .units    (frame_q[39:32]),
        .bin      (hr_bin),
        .digit_ok (hr_dig)
    );

    ascii_pair_dec u_dec_min (
        .tens     (frame_q[31:24]),
        .units    (frame_q[23:16]),
        .bin      (mn_bin),
        .digit_ok (mn_dig)
    );

    ascii_pair_dec u_dec_sec (
        .tens     (frame_q[15:8]),
        .units    (frame_q[7:0]),
        .bin      (sc_bin),
        .digit_ok (sc_dig)
    );

    assign frame_ok = hr_dig && mn_dig && sc_dig &&
                      (hr_bin <= HR_MAX) && (mn_bin <= MIN_MAX) && (sc_bin <= SEC_MAX);

    // UTC hour plus offset, folded back into 0..23 (no date handling)
    always_comb begin
        hr_sum = $signed({1'b0, hr_bin}) + TZ8;
        if (hr_sum < 0)
            hr_sum = hr_sum + 8'sd24;
        else if (hr_sum >= 8'sd24)
            hr_sum = hr_sum - 8'sd24;
        hr_local = 5'(hr_sum);
    end

    assign load      = (state_q == ST_CHECK) && frame_ok;
    assign reject    = (state_q == ST_CHECK) && !frame_ok;
    assign running   = (state_q == ST_RUN) || (state_q == ST_HOLDOVER) ||
                       ((state_q == ST_CHECK) && (ret_q != ST_UNSYNC));
    assign wrap      = running && (presc_q == PRESC_LAST);
    assign tick_now  = wrap && !load;
    assign stale_hit = tick_now && (stale_q == STALE_LAST);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_UNSYNC;
            ret_q   <= ST_UNSYNC;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
        end
    end

    // ret tracks where a failed CHECK must go back to, including a RUN that
    // went stale while the frame was being checked
    always_comb begin
        state_d = state_q;
        ret_d   = ret_q;
        capture = 1'b0;
        case (state_q)
            ST_UNSYNC, ST_RUN, ST_HOLDOVER: begin
                if (bus.time_in_valid) begin
                    capture = 1'b1;
                    state_d = ST_CHECK;
                    ret_d   = (state_q == ST_RUN && stale_hit) ? ST_HOLDOVER : state_q;
                end else if (state_q == ST_RUN && stale_hit) begin
                    state_d = ST_HOLDOVER;
                end
            end
            ST_CHECK: begin
                if (frame_ok)
                    state_d = ST_RUN;
                else if (ret_q == ST_RUN && stale_hit)
                    state_d = ST_HOLDOVER;
                else
                    state_d = ret_q;
            end
            default: state_d = ST_UNSYNC;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            frame_q <= '0;
            presc_q <= '0;
            stale_q <= '0;
            hour_q  <= '0;
            min_q   <= '0;
            sec_q   <= '0;
            tick_q  <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            tick_q <= tick_now;
            err_q  <= reject;
            if (capture)
                frame_q <= bus.time_in;
            if (load) begin
                presc_q <= '0;
                stale_q <= '0;
                hour_q  <= hr_local;
                min_q   <= mn_bin[5:0];
                sec_q   <= sc_bin[5:0];
                valid_q <= 1'b1;
            end else begin
                if (running)
                    presc_q <= wrap ? '0 : presc_q + PW'(1);
                if (tick_now) begin
                    if (stale_q != STALE_MAX)
                        stale_q <= stale_q + SW'(1);
                    if (sec_q == 6'(SEC_MAX)) begin
                        sec_q <= '0;
                        if (min_q == 6'(MIN_MAX)) begin
                            min_q  <= '0;
                            hour_q <= (hour_q == 5'(HR_MAX)) ? 5'd0 : hour_q + 5'd1;
                        end else begin
                            min_q <= min_q + 6'd1;
                        end
                    end else begin
                        sec_q <= sec_q + 6'd1;
                    end
                end
                if (stale_hit)
                    valid_q <= 1'b0;
            end
        end
    end

    assign bus.hour_out   = hour_q;
    assign bus.min_out    = min_q;
    assign bus.sec_out    = sec_q;
    assign bus.sec_tick   = tick_q;
    assign bus.time_valid = valid_q;
    assign bus.sync_err   = err_q;

endmodule
